// File: rtl/sm3_arbiter.sv
// Round-robin front-end sharing one sm3 core between N_REQ byte-stream requesters.
// Grants whole messages, paces 64-byte blocks, and returns the digest tagged with the owner.
module sm3_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int GAP_CYC = 8,
    parameter int TIMEOUT = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           sm3_data,
    output logic                 data_vld,
    output logic                 vld_end,
    input  logic [255:0]         sm3_result,
    input  logic                 result_vld,
    output logic [255:0]         digest,
    output logic                 digest_vld,
    output logic [ID_W-1:0]      digest_id,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STREAM = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYC);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

    logic [2:0]      state_q, state_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [5:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic [15:0]     timer_q, timer_d;
    logic [7:0]      sm3_data_q, sm3_data_d;
    logic            data_vld_q, data_vld_d;
    logic            vld_end_q, vld_end_d;
    logic [255:0]    digest_q, digest_d;
    logic [ID_W-1:0] digest_id_q, digest_id_d;
    logic            digest_vld_q, digest_vld_d;
    logic            timeout_err_q, timeout_err_d;

    logic            arb_hit;
    logic [ID_W-1:0] arb_id;
    logic [ID_W:0]   arb_dist;
    logic [ID_W:0]   best_dist;
    logic [7:0]      sel_data;
    logic            sel_valid;
    logic            sel_last;
    logic            hs;
    logic [ID_W-1:0] rr_next;

    // Rotating priority: the winner is the valid lane at the smallest distance past rr_ptr.
    always_comb begin
        arb_hit   = 1'b0;
        arb_id    = '0;
        arb_dist  = '0;
        best_dist = '1;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            arb_dist = (ID_W+1)'(i) - {1'b0, rr_ptr_q};
            if (arb_dist[ID_W]) begin
                arb_dist = arb_dist + (ID_W+1)'(N_REQ);
            end
            if (req_valid[i] && (!arb_hit || arb_dist < best_dist)) begin
                arb_hit   = 1'b1;
                best_dist = arb_dist;
                arb_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_id_q == ID_W'(i)) begin
                sel_data  = req_data[8*i +: 8];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                req_ready[i] = (state_q == S_STREAM);
            end
        end
    end

    assign hs      = sel_valid && (state_q == S_STREAM);
    assign rr_next = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        gnt_id_d      = gnt_id_q;
        rr_ptr_d      = rr_ptr_q;
        byte_cnt_d    = byte_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        timer_d       = timer_q;
        sm3_data_d    = sm3_data_q;
        data_vld_d    = 1'b0;
        vld_end_d     = 1'b0;
        digest_d      = digest_q;
        digest_id_d   = digest_id_q;
        digest_vld_d  = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_hit) begin
                    gnt_id_d   = arb_id;
                    byte_cnt_d = '0;
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                if (hs) begin
                    sm3_data_d = sel_data;
                    data_vld_d = 1'b1;
                    vld_end_d  = sel_last;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (sel_last) begin
                        timer_d = '0;
                        state_d = S_WAIT;
                    end else if (byte_cnt_q == 6'd63) begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q <= 8'd1) begin
                    state_d = S_STREAM;
                end
            end
            S_WAIT: begin
                if (result_vld) begin
                    digest_d    = sm3_result;
                    digest_id_d = gnt_id_q;
                    state_d     = S_DONE;
                end else if (timer_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = rr_next;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_DONE: begin
                // DONE spans two cycles: the first raises digest_vld, the second returns to IDLE.
                if (!digest_vld_q) begin
                    digest_vld_d = 1'b1;
                end else begin
                    rr_ptr_d = rr_next;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            gnt_id_q      <= '0;
            rr_ptr_q      <= '0;
            byte_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            timer_q       <= '0;
            sm3_data_q    <= '0;
            data_vld_q    <= 1'b0;
            vld_end_q     <= 1'b0;
            digest_q      <= '0;
            digest_id_q   <= '0;
            digest_vld_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_id_q      <= gnt_id_d;
            rr_ptr_q      <= rr_ptr_d;
            byte_cnt_q    <= byte_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            timer_q       <= timer_d;
            sm3_data_q    <= sm3_data_d;
            data_vld_q    <= data_vld_d;
            vld_end_q     <= vld_end_d;
            digest_q      <= digest_d;
            digest_id_q   <= digest_id_d;
            digest_vld_q  <= digest_vld_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign sm3_data    = sm3_data_q;
    assign data_vld    = data_vld_q;
    assign vld_end     = vld_end_q;
    assign digest      = digest_q;
    assign digest_id   = digest_id_q;
    assign digest_vld  = digest_vld_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sm3_arbiter.sv
// Scoreboard bench for sm3_arbiter: requester lanes, a stand-in sm3 core, and a negedge monitor.
`timescale 1ns/1ps
module tb_sm3_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int GAP_CYC = 8;
    localparam int TIMEOUT = 40;
    localparam logic [255:0] ABC_DIGEST =
        256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_REQ-1:0]     req_valid;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ-1:0]     req_ready;
    logic [7:0]           sm3_data;
    logic                 data_vld;
    logic                 vld_end;
    logic [255:0]         sm3_result;
    logic                 result_vld;
    logic [255:0]         digest;
    logic                 digest_vld;
    logic [ID_W-1:0]      digest_id;
    logic                 busy;
    logic                 timeout_err;

    sm3_arbiter #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W),
        .GAP_CYC (GAP_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .sm3_data    (sm3_data),
        .data_vld    (data_vld),
        .vld_end     (vld_end),
        .sm3_result  (sm3_result),
        .result_vld  (result_vld),
        .digest      (digest),
        .digest_vld  (digest_vld),
        .digest_id   (digest_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [8:0]        lane_q [N_REQ][$];
    logic [N_REQ-1:0]  hs = '0;
    logic [8:0]        exp_b[$];
    logic [ID_W+255:0] exp_d[$];
    int runs[$];
    int gaps[$];
    int gnt_log[$];

    int n_dig = 0, n_to = 0, n_bytes = 0, ends_seen = 0;
    int stray_cnt = 0, drop_idx = -1, rv_cyc = 0, last_id = 0, cur_lane = 0;
    bit use_abc = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int lane, input int len, input logic [7:0] base);
        for (int k = 0; k < len; k++) begin
            logic lst;
            lst = (k == len - 1);
            lane_q[lane].push_back({lst, 8'(int'(base) + k)});
        end
    endtask

    // Requester lanes: present the head byte, pop it after a handshake.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (!rst_n) lane_q[i].delete();
                else if (hs[i] && lane_q[i].size() != 0) void'(lane_q[i].pop_front());
                if (lane_q[i].size() != 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[8*i +: 8]   = lane_q[i][0][7:0];
                    req_last[i]          = lane_q[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Stand-in core: answers each finished message after a short delay unless told to drop it.
    int stray_done = 0;
    int ends_served = 0;
    initial begin
        int dly;
        logic [255:0] val;
        dly = 3;
        result_vld = 1'b0;
        sm3_result = '0;
        forever begin
            @(posedge clk);
            #1;
            result_vld = 1'b0;
            if (!rst_n) begin
                ends_served = ends_seen;
                dly = 3;
            end else if (stray_done != stray_cnt) begin
                stray_done++;
                result_vld = 1'b1;
                sm3_result = {8{32'hdeadbeef}};
            end else if (ends_served != ends_seen) begin
                if (dly != 0) dly--;
                else begin
                    dly = 3;
                    if (ends_served != drop_idx) begin
                        val = use_abc ? ABC_DIGEST : {8{8'(8'hA0 + last_id), 24'(ends_served)}};
                        result_vld = 1'b1;
                        sm3_result = val;
                        exp_d.push_back({ID_W'(last_id), val});
                        rv_cyc = cyc;
                    end
                    ends_served++;
                end
            end
        end
    end

    // Monitor: all DUT outputs are sampled on the falling edge.
    bit in_msg = 0, granted = 0, dv_seen = 0, to_arm = 0;
    int run = 0, gap = 0, to_cnt = 0;
    always @(negedge clk) begin
        logic [8:0]        e;
        logic [ID_W+255:0] d;
        if (!rst_n) begin
            exp_b.delete();
            exp_d.delete();
            hs = '0;
            in_msg = 0; granted = 0; dv_seen = 0; to_arm = 0;
            run = 0; gap = 0;
        end else begin
            if (busy) check("ready_onehot", $countones(req_ready) <= 1, 1);
            else check("ready_idle", req_ready, 0);

            if (!busy) granted = 0;
            else if (!granted && req_ready != 0) begin
                for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gnt_log.push_back(i);
                granted = 1;
            end

            if (to_arm) begin
                to_cnt++;
                if (timeout_err) begin
                    check("timeout_lat", to_cnt, TIMEOUT);
                    check("busy_after_to", busy, 0);
                    to_arm = 0;
                    n_to++;
                end
            end else check("timeout_spurious", timeout_err, 0);

            if (digest_vld) begin
                if (exp_d.size() == 0) check("digest_vld_unexp", digest_vld, 0);
                else begin
                    d = exp_d.pop_front();
                    check("digest_id", digest_id, d[ID_W+255:256]);
                    check("digest", digest, d[255:0]);
                    check("digest_lat", cyc - rv_cyc, 2);
                    check("busy_at_dvld", busy, 1);
                    n_dig++;
                end
                dv_seen = 1;
                to_arm = 0;
            end else if (dv_seen) begin
                check("busy_fall", busy, 0);
                dv_seen = 0;
            end

            if (data_vld) begin
                n_bytes++;
                if (exp_b.size() == 0) check("data_vld_unexp", data_vld, 0);
                else begin
                    e = exp_b.pop_front();
                    check("sm3_data", sm3_data, e[7:0]);
                    check("vld_end", vld_end, e[8]);
                end
                if (gap > 0) gaps.push_back(gap);
                gap = 0;
                run++;
                in_msg = 1;
                if (vld_end) begin
                    runs.push_back(run);
                    run = 0;
                    in_msg = 0;
                    last_id = cur_lane;
                    ends_seen++;
                    to_cnt = 0;
                    to_arm = 1;
                end
            end else begin
                check("vld_end_alone", vld_end, 0);
                if (in_msg) begin
                    if (run > 0) runs.push_back(run);
                    run = 0;
                    gap++;
                end
            end

            for (int i = 0; i < N_REQ; i++) begin
                hs[i] = req_valid[i] & req_ready[i];
                if (hs[i]) begin
                    exp_b.push_back({req_last[i], req_data[8*i +: 8]});
                    cur_lane = i;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_dig(input int target);
        int b = 0;
        while (n_dig < target && b < 3000) begin
            @(negedge clk);
            b++;
        end
        check("digest_count", n_dig, target);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_bytes(input int target);
        int b = 0;
        while (n_bytes < target && b < 500) begin
            @(negedge clk);
            b++;
        end
        check("byte_progress", n_bytes >= target, 1);
    endtask

    task automatic expect_q(input string tag, input int got_size, input int want_size);
        check(tag, got_size, want_size);
    endtask

    initial begin
        int d0, b0, t0, r, bnd;

        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_sm3_data", sm3_data, 0);
        check("rst_data_vld", data_vld, 0);
        check("rst_vld_end", vld_end, 0);
        check("rst_digest", digest, 0);
        check("rst_digest_vld", digest_vld, 0);
        check("rst_digest_id", digest_id, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);

        // "abc" on lane 2
        use_abc = 1'b1;
        gnt_log.delete(); runs.delete(); gaps.delete();
        send(2, 3, 8'h61);
        wait_dig(1);
        use_abc = 1'b0;
        expect_q("abc_grants", gnt_log.size(), 1);
        r = (gnt_log.size() != 0) ? gnt_log.pop_front() : -1;
        check("abc_grant_lane", r, 2);
        expect_q("abc_runs", runs.size(), 1);
        r = (runs.size() != 0) ? runs.pop_front() : -1;
        check("abc_run_len", r, 3);

        // four requesters at once after reset
        do_reset();
        gnt_log.delete();
        d0 = n_dig;
        for (int i = 0; i < N_REQ; i++) send(i, 5, 8'(8'h10 * i));
        wait_dig(d0 + 4);
        expect_q("rr_grants", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            r = (gnt_log.size() != 0) ? gnt_log.pop_front() : -1;
            check("rr_order", r, i);
        end

        // 130-byte message: two pacing gaps
        runs.delete(); gaps.delete();
        d0 = n_dig;
        send(1, 130, 8'h00);
        wait_dig(d0 + 1);
        expect_q("m130_runs", runs.size(), 3);
        expect_q("m130_gaps", gaps.size(), 2);
        for (int i = 0; i < 3; i++) begin
            r = (runs.size() != 0) ? runs.pop_front() : -1;
            check("m130_run_len", r, (i == 2) ? 2 : 64);
        end
        for (int i = 0; i < 2; i++) begin
            r = (gaps.size() != 0) ? gaps.pop_front() : -1;
            check("m130_gap_len", r, GAP_CYC);
        end

        // exactly 64 bytes: no gap
        runs.delete(); gaps.delete();
        d0 = n_dig;
        send(0, 64, 8'h80);
        wait_dig(d0 + 1);
        expect_q("m64_runs", runs.size(), 1);
        expect_q("m64_gaps", gaps.size(), 0);
        r = (runs.size() != 0) ? runs.pop_front() : -1;
        check("m64_run_len", r, 64);

        // stray result_vld during STREAM
        d0 = n_dig;
        b0 = n_bytes;
        send(3, 20, 8'hC0);
        wait_bytes(b0 + 3);
        stray_cnt++;
        wait_dig(d0 + 1);
        repeat (20) @(negedge clk);
        check("stray_ignored", n_dig, d0 + 1);

        // timeout in WAIT_RES, then next lane in rotation
        do_reset();
        gnt_log.delete();
        drop_idx = ends_seen;
        t0 = n_to;
        d0 = n_dig;
        send(1, 4, 8'h40);
        bnd = 0;
        while (gnt_log.size() == 0 && bnd < 50) begin @(negedge clk); bnd++; end
        send(0, 4, 8'h50);
        send(2, 4, 8'h60);
        bnd = 0;
        while (n_to == t0 && bnd < TIMEOUT + 100) begin @(negedge clk); bnd++; end
        check("timeout_count", n_to, t0 + 1);
        wait_dig(d0 + 2);
        check("timeout_total", n_to, t0 + 1);
        expect_q("to_grants", gnt_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            r = (gnt_log.size() != 0) ? gnt_log.pop_front() : -1;
            check("to_order", r, (i == 0) ? 1 : (i == 1) ? 2 : 0);
        end

        // asynchronous reset mid-message
        b0 = n_bytes;
        send(3, 40, 8'h70);
        wait_bytes(b0 + 5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 0);
        check("arst_data_vld", data_vld, 0);
        check("arst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        gnt_log.delete();
        d0 = n_dig;
        send(3, 4, 8'h90);
        send(0, 4, 8'hA0);
        wait_dig(d0 + 2);
        expect_q("arst_grants", gnt_log.size(), 2);
        for (int i = 0; i < 2; i++) begin
            r = (gnt_log.size() != 0) ? gnt_log.pop_front() : -1;
            check("arst_order", r, (i == 0) ? 0 : 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
        $fatal(1);
    end

endmodule
